// File: rtl/int_branch_result_queue.sv
// Branch-result queue: compacts resolved integer branch lanes into a circular buffer for predictor update.
// Latency: push to popValid is one cycle; with RSD_BR_RESULT_QUEUE_BYPASS_EN an empty queue forwards the lowest lane in the same cycle.
// Backpressure: pushStall is raised from registered occupancy when free < INT_ISSUE_WIDTH; pop is a popValid/popReady handshake.
module int_branch_result_queue #(
    parameter int INT_ISSUE_WIDTH = 2,
    parameter int QUEUE_DEPTH     = 8,
    parameter int ADDR_WIDTH      = 32,
    parameter int GH_WIDTH        = 10
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      flush,
    input  logic [INT_ISSUE_WIDTH-1:0]                pushValid,
    input  logic [INT_ISSUE_WIDTH-1:0][ADDR_WIDTH-1:0] pushPc,
    input  logic [INT_ISSUE_WIDTH-1:0][ADDR_WIDTH-1:0] pushNextAddr,
    input  logic [INT_ISSUE_WIDTH-1:0]                pushTaken,
    input  logic [INT_ISSUE_WIDTH-1:0]                pushIsCondBr,
    input  logic [INT_ISSUE_WIDTH-1:0]                pushMisPred,
    input  logic [INT_ISSUE_WIDTH-1:0][GH_WIDTH-1:0]  pushGlobalHistory,
    output logic                                      pushStall,
    output logic                                      popValid,
    input  logic                                      popReady,
    output logic [ADDR_WIDTH-1:0]                     popPc,
    output logic [ADDR_WIDTH-1:0]                     popNextAddr,
    output logic                                      popTaken,
    output logic                                      popIsCondBr,
    output logic                                      popMisPred,
    output logic [GH_WIDTH-1:0]                       popHistory,
    output logic [$clog2(QUEUE_DEPTH):0]              count,
    output logic [15:0]                               misPredCount,
    output logic                                      overflow
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] next_addr;
        logic                  taken;
        logic                  cond;
        logic                  mis;
        logic [GH_WIDTH-1:0]   hist;
    } entry_t;

    entry_t                     r_mem [QUEUE_DEPTH];
    logic [PW-1:0]              r_head;
    logic [PW-1:0]              r_tail;
    logic [CW-1:0]              r_count;
    logic [15:0]                r_mis_cnt;
    logic                       r_overflow;

    entry_t                     w_lane [INT_ISSUE_WIDTH];
    entry_t                     w_head_ent;
    logic [INT_ISSUE_WIDTH-1:0] w_enq_mask;
    logic [PW-1:0]              w_slot [INT_ISSUE_WIDTH];
    logic [CW-1:0]              w_enq_num;
    logic [CW-1:0]              w_free;
    logic                       w_accept;
    logic                       w_pop_fire;
    logic                       w_deq_queue;

    // Build per-lane entries; conditional branches shift their resolved direction into the history.
    always_comb begin
        for (int i = 0; i < INT_ISSUE_WIDTH; i++) begin
            w_lane[i].pc        = pushPc[i];
            w_lane[i].next_addr = pushNextAddr[i];
            w_lane[i].taken     = pushTaken[i];
            w_lane[i].cond      = pushIsCondBr[i];
            w_lane[i].mis       = pushMisPred[i];
            w_lane[i].hist      = pushIsCondBr[i]
                                ? ((pushGlobalHistory[i] << 1) | GH_WIDTH'(pushTaken[i]))
                                : pushGlobalHistory[i];
        end
    end

`ifdef RSD_BR_RESULT_QUEUE_BYPASS_EN
    logic [INT_ISSUE_WIDTH-1:0] w_first_oh;
    logic                       w_byp_active;
    entry_t                     w_byp_ent;

    // Pick the lowest valid lane as the forwarding candidate while the queue is empty.
    always_comb begin
        w_first_oh   = pushValid & (~pushValid + INT_ISSUE_WIDTH'(1));
        w_byp_active = (r_count == '0) && !flush && (|pushValid);
        w_byp_ent    = '0;
        for (int i = 0; i < INT_ISSUE_WIDTH; i++) begin
            if (w_first_oh[i]) begin
                w_byp_ent = w_lane[i];
            end
        end
    end

    assign popValid    = (r_count != '0) || w_byp_active;
    assign w_head_ent  = w_byp_active ? w_byp_ent : r_mem[r_head];
    // A forwarded lane that is consumed this cycle never occupies a slot.
    assign w_enq_mask  = (w_byp_active && popReady) ? (pushValid & ~w_first_oh) : pushValid;
    assign w_deq_queue = popValid && popReady && !w_byp_active;
`else
    assign popValid    = (r_count != '0);
    assign w_head_ent  = r_mem[r_head];
    assign w_enq_mask  = pushValid;
    assign w_deq_queue = popValid && popReady;
`endif

    assign w_pop_fire = popValid && popReady;

    // Compact enqueued lanes into consecutive slots from tail and decide whether the group fits.
    always_comb begin
        w_enq_num = '0;
        for (int i = 0; i < INT_ISSUE_WIDTH; i++) begin
            w_slot[i] = r_tail + w_enq_num[PW-1:0];
            if (w_enq_mask[i]) begin
                w_enq_num = w_enq_num + CW'(1);
            end
        end
        // A same-cycle pop does not free its slot yet, so room is judged on registered occupancy.
        w_free   = CW'(QUEUE_DEPTH) - r_count;
        w_accept = (w_enq_num <= w_free);
    end

    // Pointer, occupancy and status update; flush empties the queue but keeps the statistics.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_mis_cnt  <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_tail <= r_tail + w_enq_num[PW-1:0];
            end else begin
                // Whole group is dropped; the loss is remembered until reset.
                r_overflow <= 1'b1;
            end
            if (w_deq_queue) begin
                r_head <= r_head + PW'(1);
            end
            r_count <= r_count + (w_accept ? w_enq_num : '0) - (w_deq_queue ? CW'(1) : '0);
            if (w_pop_fire && w_head_ent.mis && (r_mis_cnt != 16'hFFFF)) begin
                r_mis_cnt <= r_mis_cnt + 16'd1;
            end
        end
    end

    // Write accepted lanes into their compacted slots; storage contents are never cleared.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && w_accept) begin
            for (int i = 0; i < INT_ISSUE_WIDTH; i++) begin
                if (w_enq_mask[i]) begin
                    r_mem[w_slot[i]] <= w_lane[i];
                end
            end
        end
    end

    assign pushStall    = (w_free < CW'(INT_ISSUE_WIDTH));
    assign popPc        = w_head_ent.pc;
    assign popNextAddr  = w_head_ent.next_addr;
    assign popTaken     = w_head_ent.taken;
    assign popIsCondBr  = w_head_ent.cond;
    assign popMisPred   = w_head_ent.mis;
    assign popHistory   = w_head_ent.hist;
    assign count        = r_count;
    assign misPredCount = r_mis_cnt;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_int_branch_result_queue.sv
// Bench for int_branch_result_queue: directed vector table plus random traffic against a queue model.
// Latency: outputs are sampled 1ns after inputs change at the falling edge.
// Backpressure: popReady and pushValid are driven by the table or randomly.
module tb_int_branch_result_queue;

    localparam int DEPTH = 8;
`ifdef RSD_BR_RESULT_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n, flush, popReady;
    logic [1:0]       pushValid, pushTaken, pushIsCondBr, pushMisPred;
    logic [1:0][31:0] pushPc, pushNextAddr;
    logic [1:0][9:0]  pushGlobalHistory;
    logic             pushStall, popValid, popTaken, popIsCondBr, popMisPred, overflow;
    logic [31:0]      popPc, popNextAddr;
    logic [9:0]       popHistory;
    logic [3:0]       count;
    logic [15:0]      misPredCount;

    int n_vec = 0;
    int n_mis = 0;

    int_branch_result_queue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .pushValid(pushValid), .pushPc(pushPc), .pushNextAddr(pushNextAddr),
        .pushTaken(pushTaken), .pushIsCondBr(pushIsCondBr), .pushMisPred(pushMisPred),
        .pushGlobalHistory(pushGlobalHistory), .pushStall(pushStall),
        .popValid(popValid), .popReady(popReady), .popPc(popPc), .popNextAddr(popNextAddr),
        .popTaken(popTaken), .popIsCondBr(popIsCondBr), .popMisPred(popMisPred),
        .popHistory(popHistory), .count(count), .misPredCount(misPredCount), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit rst; bit fl; bit [1:0] pv; bit [31:0] pc0; bit [31:0] pc1;
        bit cond; bit tk; bit mis; bit [9:0] gh; bit rdy;
        bit e_pv; bit [31:0] e_pc; bit [9:0] e_hist; bit [3:0] e_cnt;
        bit e_stall; bit e_ovf; bit [15:0] e_mis; bit chk;
    } vec_t;
    vec_t tv[$];

    function automatic void add(bit rst, bit fl, bit [1:0] pv, bit [31:0] pc0, bit [31:0] pc1,
                                bit cond, bit tk, bit mis, bit [9:0] gh, bit rdy,
                                bit e_pv, bit [31:0] e_pc, bit [9:0] e_hist, bit [3:0] e_cnt,
                                bit e_stall, bit e_ovf, bit [15:0] e_mis, bit c);
        vec_t v;
        v.rst = rst; v.fl = fl; v.pv = pv; v.pc0 = pc0; v.pc1 = pc1;
        v.cond = cond; v.tk = tk; v.mis = mis; v.gh = gh; v.rdy = rdy;
        v.e_pv = e_pv; v.e_pc = e_pc; v.e_hist = e_hist; v.e_cnt = e_cnt;
        v.e_stall = e_stall; v.e_ovf = e_ovf; v.e_mis = e_mis; v.chk = c;
        tv.push_back(v);
    endfunction

    task automatic drive(bit rst, bit fl, bit [1:0] pv, bit [31:0] pc0, bit [31:0] pc1,
                         bit cond, bit tk, bit mis, bit [9:0] gh, bit rdy);
        rst_n = rst; flush = fl; pushValid = pv; popReady = rdy;
        pushPc[0] = pc0; pushPc[1] = pc1;
        pushNextAddr[0] = pc0 + 32'h40; pushNextAddr[1] = pc1 + 32'h40;
        pushIsCondBr = {cond, cond}; pushTaken = {tk, tk}; pushMisPred = {mis, mis};
        pushGlobalHistory[0] = gh; pushGlobalHistory[1] = gh;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit [31:0] pc; bit [31:0] na; bit tk; bit cond; bit mis; bit [9:0] hist;
    } ent_t;
    ent_t      mq[$];
    bit [15:0] m_mis;
    bit        m_ovf;
    bit        m_known = 1'b0;

    function automatic ent_t mk_lane(int i);
        ent_t e;
        bit [9:0] h;
        e.pc = pushPc[i]; e.na = pushNextAddr[i]; e.tk = pushTaken[i];
        e.cond = pushIsCondBr[i]; e.mis = pushMisPred[i];
        h = pushGlobalHistory[i];
        if (pushIsCondBr[i]) begin
            h = h << 1;
            h[0] = pushTaken[i];
        end
        e.hist = h;
        return e;
    endfunction

    task automatic model_check();
        ent_t lanes[$];
        ent_t hd;
        bit   exp_vld;
        for (int i = 0; i < 2; i++) if (pushValid[i]) lanes.push_back(mk_lane(i));
        exp_vld = (mq.size() > 0) || (BYP && !flush && lanes.size() > 0);
        chk("popValid", {31'd0, popValid}, {31'd0, exp_vld});
        chk("count", {28'd0, count}, mq.size());
        chk("pushStall", {31'd0, pushStall}, {31'd0, (DEPTH - mq.size()) < 2});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("misPredCount", {16'd0, misPredCount}, {16'd0, m_mis});
        if (exp_vld) begin
            hd = (mq.size() > 0) ? mq[0] : lanes[0];
            chk("popPc", popPc, hd.pc);
            chk("popNextAddr", popNextAddr, hd.na);
            chk("popFlags", {29'd0, popTaken, popIsCondBr, popMisPred}, {29'd0, hd.tk, hd.cond, hd.mis});
            chk("popHistory", {22'd0, popHistory}, {22'd0, hd.hist});
        end
    endtask

    task automatic model_step();
        ent_t lanes[$];
        int   free;
        for (int i = 0; i < 2; i++) if (pushValid[i]) lanes.push_back(mk_lane(i));
        if (!rst_n) begin
            mq.delete(); m_mis = 0; m_ovf = 0; m_known = 1'b1;
        end else if (flush) begin
            mq.delete();
        end else begin
            free = DEPTH - mq.size();
            if (BYP && mq.size() == 0 && lanes.size() > 0) begin
                if (popReady) begin
                    if (lanes[0].mis && m_mis != 16'hFFFF) m_mis++;
                    void'(lanes.pop_front());
                end
            end else if (mq.size() > 0 && popReady) begin
                if (mq[0].mis && m_mis != 16'hFFFF) m_mis++;
                void'(mq.pop_front());
            end
            if (lanes.size() > free) m_ovf = 1'b1;
            else foreach (lanes[k]) mq.push_back(lanes[k]);
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset, single lane-1 push with immediate drain.
        add(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        add(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        add(1,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,1);
        add(1,0,2'b10,0,'h100,0,0,0,0,1, 0,0,0,0,0,0,0,1);
        add(1,0,0,0,0,0,0,0,0,1, 1,'h100,0,1,0,0,0,1);
        add(1,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,1);
        // Fill to full with both lanes, then drain in order.
        for (int k = 0; k < 4; k++)
            add(1,0,2'b11,'h200+8*k,'h204+8*k,0,0,0,0,0, k>0,'h200,0,4'(2*k),0,0,0,1);
        add(1,0,0,0,0,0,0,0,0,0, 1,'h200,0,8,1,0,0,1);
        for (int k = 0; k < 8; k++)
            add(1,0,0,0,0,0,0,0,0,1, 1,'h200+4*k,0,4'(8-k),(8-k)>6,0,0,1);
        add(1,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,1);
        // Reach 7, drop an oversized group, accept a fitting one under stall.
        for (int k = 0; k < 3; k++)
            add(1,0,2'b11,'h300+8*k,'h304+8*k,0,0,0,0,0, k>0,'h300,0,4'(2*k),0,0,0,1);
        add(1,0,2'b01,'h318,0,0,0,0,0,0, 1,'h300,0,6,0,0,0,1);
        add(1,0,2'b11,'h400,'h404,0,0,0,0,0, 1,'h300,0,7,1,0,0,1);
        add(1,0,2'b10,0,'h408,0,0,0,0,0, 1,'h300,0,7,1,1,0,1);
        add(1,0,0,0,0,0,0,0,0,0, 1,'h300,0,8,1,1,0,1);
        for (int k = 0; k < 8; k++)
            add(1,0,0,0,0,0,0,0,0,1, 1,(k < 7) ? 'h300+4*k : 'h408,0,4'(8-k),(8-k)>6,1,0,1);
        add(1,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,1,0,1);
        // History folding for conditional and unconditional branches.
        add(1,0,2'b01,'h500,0,1,1,0,'h155,0, 0,0,0,0,0,1,0,1);
        add(1,0,0,0,0,0,0,0,0,1, 1,'h500,'h2AB,1,0,1,0,1);
        add(1,0,2'b01,'h504,0,0,1,0,'h155,0, 0,0,0,0,0,1,0,1);
        add(1,0,0,0,0,0,0,0,0,1, 1,'h504,'h155,1,0,1,0,1);
        add(1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,1,0,1);
        // Mispredict counting, then flush with same-cycle push and pop at count 5.
        add(1,0,2'b11,'h600,'h604,0,0,1,0,0, 0,0,0,0,0,1,0,1);
        add(1,0,2'b11,'h608,'h60C,0,0,1,0,0, 1,'h600,0,2,0,1,0,1);
        add(1,0,2'b01,'h610,0,0,0,0,0,0, 1,'h600,0,4,0,1,0,1);
        add(1,0,0,0,0,0,0,0,0,1, 1,'h600,0,5,0,1,0,1);
        add(1,0,2'b01,'h614,0,0,0,0,0,0, 1,'h604,0,4,0,1,1,1);
        add(1,1,2'b11,'h700,'h704,0,0,1,0,1, 1,'h604,0,5,0,1,1,1);
        add(1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,1,1,1);
        // Reset clears the sticky overflow and the mispredict counter.
        add(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        add(1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1);

`ifndef RSD_BR_RESULT_QUEUE_BYPASS_EN
        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            drive(tv[i].rst, tv[i].fl, tv[i].pv, tv[i].pc0, tv[i].pc1,
                  tv[i].cond, tv[i].tk, tv[i].mis, tv[i].gh, tv[i].rdy);
            #1;
            if (tv[i].chk) begin
                chk($sformatf("v%0d.popValid", i), {31'd0, popValid}, {31'd0, tv[i].e_pv});
                chk($sformatf("v%0d.count", i), {28'd0, count}, {28'd0, tv[i].e_cnt});
                chk($sformatf("v%0d.pushStall", i), {31'd0, pushStall}, {31'd0, tv[i].e_stall});
                chk($sformatf("v%0d.overflow", i), {31'd0, overflow}, {31'd0, tv[i].e_ovf});
                chk($sformatf("v%0d.misPredCount", i), {16'd0, misPredCount}, {16'd0, tv[i].e_mis});
                if (tv[i].e_pv) begin
                    chk($sformatf("v%0d.popPc", i), popPc, tv[i].e_pc);
                    chk($sformatf("v%0d.popHistory", i), {22'd0, popHistory}, {22'd0, tv[i].e_hist});
                end
            end
        end
`else
        // Empty-queue forwarding: lane 0 shows up and is consumed in the same cycle.
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk); drive(1, 0, 2'b01, 'h900, 0, 0, 0, 0, 0, 1);
        #1;
        chk("byp.popValid", {31'd0, popValid}, 32'd1);
        chk("byp.popPc", popPc, 32'h900);
        chk("byp.count", {28'd0, count}, 32'd0);
        @(negedge clk); drive(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("byp.popValid_after", {31'd0, popValid}, 32'd0);
        chk("byp.count_after", {28'd0, count}, 32'd0);
`endif

        // Random traffic against the queue model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c < 2) begin
                drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            end else begin
                drive(($urandom_range(0, 299) != 0), ($urandom_range(0, 39) == 0),
                      2'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom),
                      1'($urandom), 10'($urandom), ($urandom_range(0, 2) != 0));
                pushTaken = 2'($urandom); pushIsCondBr = 2'($urandom);
                pushMisPred = 2'($urandom); pushGlobalHistory[1] = 10'($urandom);
                pushNextAddr[0] = $urandom; pushNextAddr[1] = $urandom;
            end
            #1;
            if (m_known) model_check();
            model_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
